sdp_wide_wr_burst_rd: RTL and testbench

SDP_WIDE_WR_BURST_RD -- requirements
Module: sdp_wide_wr_burst_rd

---
 rtl/sdp_bram_pkg.sv | 13 +
 rtl/sdp_rd_skid.sv | 52 +++++
 rtl/sdp_wide_wr_burst_rd.sv | 118 +++++++++++
 tb/tb_sdp_wide_wr_burst_rd.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sdp_bram_pkg.sv
// Shared lane geometry and burst FSM encoding for the
// wide-write / narrow-burst-read block RAM.
package sdp_bram_pkg;

  localparam int LANES = 4;
  localparam int LSEL  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/sdp_rd_skid.sv
// Two-entry output buffer with pass-through when empty.
// in_ready grants a word that will arrive on the next cycle.
module sdp_rd_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] buf_q [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt;
  logic         empty;
  logic         push;
  logic         pop;

  assign empty = (cnt == 2'd0);
  assign push  = in_valid && !(empty && out_ready);
  assign pop   = out_ready && !empty;

  // in_valid is the word already in flight, so count it as taken
  assign in_ready = empty || (cnt == 2'd1 && !in_valid);

  assign out_valid = in_valid || !empty;
  assign out_data  = !empty  ? buf_q[rptr] :
                     in_valid ? in_data : '0;

  always_ff @(posedge clk) begin
    if (push) buf_q[wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      if (push && !pop)      cnt <= cnt + 2'd1;
      else if (pop && !push) cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: rtl/sdp_wide_wr_burst_rd.sv
// Simple dual-port RAM: 4-lane wide write port,
// narrow read port driven by a short burst engine.
module sdp_wide_wr_burst_rd
  import sdp_bram_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int ABITS = 10,
  parameter int DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [ABITS-3:0]       wa,
  input  logic [4*DBITS-1:0]     wd,
  input  logic [3:0]             wbe,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ABITS-1:0]       req_addr,
  input  logic [1:0]             req_len,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DBITS-1:0]       rd_data,
  output logic                   rd_last
);

  localparam int WDEPTH = DEPTH / LANES;

  (* syn_ramstyle = "block_ram" *)
  logic [LANES*DBITS-1:0] mem [WDEPTH];

  state_t             state_q, state_d;
  logic [ABITS-1:0]   addr_q, addr_d;
  logic [1:0]         rem_q, rem_d;
  logic               issue;
  logic               last_iss;
  logic               skid_rdy;
  logic               p_valid;
  logic               p_last;
  logic [LANES*DBITS-1:0] rword;
  logic [LSEL-1:0]    rlane;
  logic [DBITS-1:0]   rdata_w;

  // Read-first: the read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (wbe[k]) mem[wa][k*DBITS +: DBITS] <= wd[k*DBITS +: DBITS];
      end
    end
    if (issue) begin
      rword <= mem[addr_q[ABITS-1:LSEL]];
      rlane <= addr_q[LSEL-1:0];
    end
  end

  assign rdata_w = rword[rlane*DBITS +: DBITS];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    issue     = 1'b0;
    last_iss  = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          rem_d   = req_len;
          state_d = BURST;
        end
      end
      BURST: begin
        if (skid_rdy) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (rem_q == 2'd0) begin
            last_iss = 1'b1;
            state_d  = IDLE;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      p_valid <= issue;
      p_last  <= last_iss;
    end
  end

  sdp_rd_skid #(
    .W(DBITS + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (p_valid),
    .in_ready (skid_rdy),
    .in_data  ({p_last, rdata_w}),
    .out_valid(rd_valid),
    .out_ready(rd_ready),
    .out_data ({rd_last, rd_data})
  );

endmodule

// File: tb/tb_sdp_wide_wr_burst_rd.sv
// Directed bench for sdp_wide_wr_burst_rd: lane writes,
// bursts, wrap, stalls, read-first and mid-burst reset.
module tb_sdp_wide_wr_burst_rd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [7:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [3:0]  wbe = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_addr = '0;
  logic [1:0]  req_len = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_last;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdp_wide_wr_burst_rd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .wbe      (wbe),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d; wbe = be;
    @(negedge clk);
    we = 1'b0; wbe = '0;
  endtask

  // Words expected on consecutive cycles starting two after acceptance
  task automatic burst(input string tag, input logic [9:0] a,
                       input logic [1:0] l, input logic [31:0] exp,
                       input bit wsame, input logic [31:0] wdat,
                       input int stop);
    @(negedge clk);
    chk({tag, "/req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_len = l; rd_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "/lat"}, {31'd0, rd_valid}, 32'd0);
    if (wsame) begin
      we = 1'b1; wa = 8'd5; wd = wdat; wbe = 4'b0001;
    end
    for (int i = 0; i <= int'(l) && i < stop; i++) begin
      @(negedge clk);
      we = 1'b0; wbe = '0;
      chk({tag, "/valid"}, {31'd0, rd_valid}, 32'd1);
      chk({tag, "/data"}, {24'd0, rd_data}, {24'd0, exp[i*8 +: 8]});
      chk({tag, "/last"}, {31'd0, rd_last}, {31'd0, i == int'(l)});
    end
    if (stop > int'(l)) begin
      @(negedge clk);
      chk({tag, "/idle"}, {31'd0, rd_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [11:0] pat;
    logic [31:0] exp4;
    int idx;
    bit stalled;
    pat  = 12'b101001101001;
    exp4 = 32'h44332211;

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst/req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst/rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst/rd_last", {31'd0, rd_last}, 32'd0);
    chk("rst/rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;

    wr(8'd5, 32'h44332211, 4'hF);
    burst("full", 10'd20, 2'd3, 32'h44332211, 1'b0, '0, 4);

    wr(8'd6, 32'h44332211, 4'hF);
    wr(8'd6, 32'hDDCCBBAA, 4'b0101);
    burst("lanes", 10'd24, 2'd3, 32'h44CC22AA, 1'b0, '0, 4);

    wr(8'd255, 32'h7E000000, 4'b1000);
    wr(8'd0, 32'h00000081, 4'b0001);
    burst("wrap", 10'd1023, 2'd1, 32'h0000817E, 1'b0, '0, 4);

    @(negedge clk);
    chk("stall/req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = 10'd20; req_len = 2'd3;
    rd_ready = 1'b0;
    idx = 0;
    stalled = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (stalled) begin
        chk("stall/hold_v", {31'd0, rd_valid}, 32'd1);
        chk("stall/hold_d", {24'd0, rd_data}, {24'd0, exp4[idx*8 +: 8]});
      end
      rd_ready = pat[c % 12];
      if (rd_valid && rd_ready) begin
        if (idx < 4) begin
          chk("stall/data", {24'd0, rd_data}, {24'd0, exp4[idx*8 +: 8]});
          chk("stall/last", {31'd0, rd_last}, {31'd0, idx == 3});
        end else begin
          chk("stall/extra", idx, 32'd3);
        end
        idx++;
      end
      stalled = rd_valid && !rd_ready;
    end
    chk("stall/count", idx, 32'd4);
    chk("stall/idle", {31'd0, rd_valid}, 32'd0);

    burst("rdfirst", 10'd20, 2'd3, 32'h44332211, 1'b1, 32'h00000055, 4);
    burst("newval", 10'd20, 2'd3, 32'h44332255, 1'b0, '0, 4);

    burst("midrst", 10'd20, 2'd3, 32'h44332255, 1'b0, '0, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst/rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("midrst/req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst/rd_last", {31'd0, rd_last}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    burst("postrst", 10'd20, 2'd0, 32'h00000055, 1'b0, '0, 4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
